car_motion: RTL and testbench
=============================

CAR_MOTION -- requirements
Module: car_motion

Interface
REQ-001 SHALL have parameter TRAVEL_CYCLES, default 8: clock cycles per one-floor step; legal range 2..255.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4: ARRIVE dwell in cycles when CAR_ARRIVE_HOLD_EN is defined; legal range 1..255.
REQ-003 SHALL have port Clock, input, 1: the single clock; all state updates on posedge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port inputfloors, input, 6: request switches; bit0=1, bit1=2, bit2=2M, bit3=3, bit4=3M, bit5=4.
REQ-006 SHALL have port doorOpen, input, 1: door-controller status; 1 = door open.
REQ-007 SHALL have port currentFloor, output, 6: one-hot car position, same bit order as inputfloors.
REQ-008 SHALL have port pending, output, 6: latched, unserved requests.
REQ-009 SHALL have port up, output, 1: car in MOVE_UP.
REQ-010 SHALL have port down, output, 1: car in MOVE_DOWN.
REQ-011 SHALL have port arrive, output, 1: high while in ARRIVE.

Function
REQ-012 SHALL latch requests every cycle: pending <= (pending | inputfloors) & ~clear, where clear is the currentFloor bit on ARRIVE entry, else 0.
REQ-013 SHALL serve a request for the arrival floor in the same cycle as ARRIVE entry, leaving that pending bit 0.
REQ-014 SHALL implement states IDLE, MOVE_UP, MOVE_DOWN and ARRIVE, with exactly one state active.
REQ-015 SHALL, in IDLE with doorOpen=0, transition as follows:
  - pending bit at currentFloor -> ARRIVE;
  - else any pending bit above -> MOVE_UP;
  - else any pending bit below -> MOVE_DOWN;
  - else stay in IDLE.
REQ-016 SHALL keep a step timer during MOVE_UP and MOVE_DOWN: it counts 0..TRAVEL_CYCLES-1; at terminal count it shifts currentFloor one bit (left for up, right for down) and clears to 0.
REQ-017 SHALL, after each step, go to ARRIVE if pending at the new floor is 1; else continue if a request lies further in the same direction; else return to IDLE.
REQ-018 SHALL freeze the step timer and currentFloor while doorOpen=1 in MOVE_UP or MOVE_DOWN, and resume counting from the held value when doorOpen returns to 0.
REQ-019 SHALL never shift currentFloor below bit0 or above bit5; a direction with no request ahead is never entered.
REQ-020 SHALL, when ARRIVE completes, return to the prior direction if requests remain ahead in it, otherwise go to IDLE; IDLE re-evaluates per REQ-015 on the next cycle.
REQ-021 SHALL drive up, down and arrive as Moore outputs decoded from the state register.
REQ-022 SHALL keep currentFloor one-hot at all times.

Reset
REQ-023 SHALL, while Reset=0, force immediately and regardless of Clock: currentFloor=6'b000001, pending=0, state=IDLE, timers=0, up=down=arrive=0.
REQ-024 SHALL, on reset asserted mid-travel, abandon the step in progress and discard all pending requests.

Configuration
REQ-025 SHALL use macro CAR_ARRIVE_HOLD_EN.
REQ-026 SHALL, with CAR_ARRIVE_HOLD_EN defined, stay in ARRIVE for HOLD_CYCLES cycles, extended while doorOpen=1, leaving only after at least one cycle with doorOpen=0 once the count is done.
REQ-027 SHALL, without CAR_ARRIVE_HOLD_EN, stay in ARRIVE exactly one cycle, ignore doorOpen in ARRIVE, and keep HOLD_CYCLES with no effect.

Verification (TRAVEL_CYCLES=8; macro undefined unless stated)
REQ-028 SHALL cover reset: Reset=0 asynchronously mid-cycle -> currentFloor=000001, pending=0, up=down=arrive=0 before the next posedge.
REQ-029 SHALL cover a single request up: inputfloors=010000 pulsed 1 cycle from floor 1 -> up=1; currentFloor advances every 8 cycles to 010000 after 32 cycles; arrive=1 for 1 cycle; pending=0.
REQ-030 SHALL cover a door interlock: doorOpen=1 for 5 cycles mid-step -> currentFloor unchanged; total travel extended by exactly 5 cycles.
REQ-031 SHALL cover direction order: at floor 000100 moving up with pending=100001 -> serve 100000 first, then MOVE_DOWN to 000001; two arrive pulses.
REQ-032 SHALL cover a same-floor request: inputfloors=000001 at floor 1 in IDLE -> ARRIVE next cycle, pending bit never visible high after ARRIVE entry.
REQ-033 SHALL cover the hold option: CAR_ARRIVE_HOLD_EN defined, HOLD_CYCLES=4, doorOpen=1 through ARRIVE -> arrive stays high until 1 cycle after doorOpen falls, minimum 4 cycles.

Source files
------------

// File: rtl/car_motion.sv
// Elevator car motion controller: latches floor requests, steps a one-hot car position
// up or down on a travel timer, and dwells in ARRIVE. Optional macro: CAR_ARRIVE_HOLD_EN.
module car_motion #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int HOLD_CYCLES   = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] inputfloors,
    input  logic       doorOpen,
    output logic [5:0] currentFloor,
    output logic [5:0] pending,
    output logic       up,
    output logic       down,
    output logic       arrive
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        ARRIVE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    localparam logic [7:0] STEP_LAST = 8'(TRAVEL_CYCLES - 1);

    if (TRAVEL_CYCLES < 2 || TRAVEL_CYCLES > 255 ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_param_check
        $error("car_motion: TRAVEL_CYCLES or HOLD_CYCLES out of range");
    end

    state_t     state;
    state_t     state_nxt;
    dir_t       dir;
    dir_t       dir_nxt;
    logic [7:0] step_cnt;
    logic [7:0] step_cnt_nxt;
    logic [5:0] floor_nxt;
    logic [5:0] ahead;
    logic [5:0] clear;
    logic       arrive_done;

    // Floors strictly below / above a one-hot position.
    function automatic logic [5:0] mask_below(input logic [5:0] f);
        return f - 6'd1;
    endfunction

    function automatic logic [5:0] mask_above(input logic [5:0] f);
        return ~(f | (f - 6'd1));
    endfunction

`ifdef CAR_ARRIVE_HOLD_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    logic [7:0] hold_cnt;

    // Dwell is over only once the count is done and the door has been seen closed.
    assign arrive_done = (hold_cnt >= HOLD_LAST) && !doorOpen;
`else
    assign arrive_done = 1'b1;
`endif

    always_comb begin
        state_nxt    = state;
        dir_nxt      = dir;
        step_cnt_nxt = step_cnt;
        floor_nxt    = currentFloor;
        ahead        = '0;
        case (state)
            IDLE: begin
                step_cnt_nxt = '0;
                if (!doorOpen) begin
                    if (|(pending & currentFloor)) begin
                        state_nxt = ARRIVE;
                        dir_nxt   = DIR_NONE;
                    end else if (|(pending & mask_above(currentFloor))) begin
                        state_nxt = MOVE_UP;
                        dir_nxt   = DIR_UP;
                    end else if (|(pending & mask_below(currentFloor))) begin
                        state_nxt = MOVE_DOWN;
                        dir_nxt   = DIR_DOWN;
                    end
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if ((state == MOVE_UP && currentFloor[5]) ||
                    (state == MOVE_DOWN && currentFloor[0])) begin
                    state_nxt    = IDLE;
                    dir_nxt      = DIR_NONE;
                    step_cnt_nxt = '0;
                end else if (!doorOpen) begin
                    if (step_cnt == STEP_LAST) begin
                        step_cnt_nxt = '0;
                        if (state == MOVE_UP) begin
                            floor_nxt = currentFloor << 1;
                            ahead     = mask_above(floor_nxt);
                        end else begin
                            floor_nxt = currentFloor >> 1;
                            ahead     = mask_below(floor_nxt);
                        end
                        if (|(pending & floor_nxt)) begin
                            state_nxt = ARRIVE;
                        end else if (!(|(pending & ahead))) begin
                            state_nxt = IDLE;
                            dir_nxt   = DIR_NONE;
                        end
                    end else begin
                        step_cnt_nxt = step_cnt + 8'd1;
                    end
                end
            end
            ARRIVE: begin
                step_cnt_nxt = '0;
                if (arrive_done) begin
                    if (dir == DIR_UP && |(pending & mask_above(currentFloor))) begin
                        state_nxt = MOVE_UP;
                    end else if (dir == DIR_DOWN && |(pending & mask_below(currentFloor))) begin
                        state_nxt = MOVE_DOWN;
                    end else begin
                        state_nxt = IDLE;
                        dir_nxt   = DIR_NONE;
                    end
                end
            end
            default: begin
                state_nxt    = IDLE;
                dir_nxt      = DIR_NONE;
                step_cnt_nxt = '0;
            end
        endcase
    end

    // The arrival floor's request is served on the entry edge itself.
    assign clear = (state_nxt == ARRIVE && state != ARRIVE) ? floor_nxt : 6'b000000;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            dir          <= DIR_NONE;
            step_cnt     <= '0;
            currentFloor <= 6'b000001;
            pending      <= '0;
            up           <= 1'b0;
            down         <= 1'b0;
            arrive       <= 1'b0;
`ifdef CAR_ARRIVE_HOLD_EN
            hold_cnt     <= '0;
`endif
        end else begin
            state        <= state_nxt;
            dir          <= dir_nxt;
            step_cnt     <= step_cnt_nxt;
            currentFloor <= floor_nxt;
            pending      <= (pending | inputfloors) & ~clear;
            up           <= (state_nxt == MOVE_UP);
            down         <= (state_nxt == MOVE_DOWN);
            arrive       <= (state_nxt == ARRIVE);
`ifdef CAR_ARRIVE_HOLD_EN
            if (state == ARRIVE && state_nxt == ARRIVE) begin
                if (hold_cnt < HOLD_LAST) begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
            end else begin
                hold_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_car_motion.sv
// Self-checking bench for car_motion (TRAVEL_CYCLES=8); arrivals are predicted into a
// scoreboard queue when requests are driven and popped when arrive is seen.
module tb_car_motion;

    logic       Clock;
    logic       Reset;
    logic [5:0] inputfloors;
    logic       doorOpen;
    logic [5:0] currentFloor;
    logic [5:0] pending;
    logic       up;
    logic       down;
    logic       arrive;

    int n_pass;
    int n_total;

    typedef struct {
        logic [5:0] floor;
        int         lat;
    } exp_t;

    exp_t sb[$];

    car_motion #(
        .TRAVEL_CYCLES(8),
        .HOLD_CYCLES(4)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .inputfloors(inputfloors),
        .doorOpen(doorOpen),
        .currentFloor(currentFloor),
        .pending(pending),
        .up(up),
        .down(down),
        .arrive(arrive)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_arrive(input int bound, inout int k, output bit timed_out);
        timed_out = 1'b1;
        while (k < bound) begin
            @(negedge Clock);
            k++;
            if (arrive === 1'b1) begin
                timed_out = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        inputfloors = '0;
        doorOpen = 1'b0;
        repeat (3) @(negedge Clock);
        n_total++;
        if (currentFloor !== 6'b000001) $display("FAIL reset_floor: got %b want %b", currentFloor, 6'b000001);
        else n_pass++;
        n_total++;
        if ({pending, up, down, arrive} !== 9'b0) $display("FAIL reset_outputs: got %b want %b", {pending, up, down, arrive}, 9'b0);
        else n_pass++;

        Reset = 1'b1;
        inputfloors = 6'b100000;
        @(negedge Clock);
        inputfloors = '0;
        repeat (12) @(negedge Clock);
        n_total++;
        if ({up, currentFloor} !== {1'b1, 6'b000010}) $display("FAIL pre_reset_travel: got %b want %b", {up, currentFloor}, {1'b1, 6'b000010});
        else n_pass++;

        #2 Reset = 1'b0;
        #1;
        n_total++;
        if (currentFloor !== 6'b000001) $display("FAIL async_reset_floor: got %b want %b", currentFloor, 6'b000001);
        else n_pass++;
        n_total++;
        if ({pending, up, down, arrive} !== 9'b0) $display("FAIL async_reset_outputs: got %b want %b", {pending, up, down, arrive}, 9'b0);
        else n_pass++;

        @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        n_total++;
        if ({pending, up, down, currentFloor} !== {6'b0, 2'b00, 6'b000001})
            $display("FAIL reset_discards: got %b want %b", {pending, up, down, currentFloor}, {6'b0, 2'b00, 6'b000001});
        else n_pass++;
    endtask

    task automatic test_single_up();
        int k;
        bit to;
        exp_t e;
        sb.delete();
        k = 0;
        inputfloors = 6'b010000;
        sb.push_back('{6'b010000, 34});
        @(negedge Clock); k = 1;
        inputfloors = '0;
        n_total++;
        if ({pending, up} !== {6'b010000, 1'b0}) $display("FAIL up_latch: got %b want %b", {pending, up}, {6'b010000, 1'b0});
        else n_pass++;
        @(negedge Clock); k = 2;
        n_total++;
        if (up !== 1'b1) $display("FAIL up_start: got %b want 1", up);
        else n_pass++;
        repeat (7) @(negedge Clock); k = 9;
        n_total++;
        if (currentFloor !== 6'b000001) $display("FAIL up_before_step: got %b want %b", currentFloor, 6'b000001);
        else n_pass++;
        @(negedge Clock); k = 10;
        n_total++;
        if (currentFloor !== 6'b000010) $display("FAIL up_first_step: got %b want %b", currentFloor, 6'b000010);
        else n_pass++;
        wait_arrive(60, k, to);
        n_total++;
        if (to) $display("FAIL up_arrive: timeout at cycle %0d", k);
        else begin
            e = sb.pop_front();
            if (currentFloor !== e.floor || k !== e.lat)
                $display("FAIL up_arrive: got floor %b cycle %0d want floor %b cycle %0d", currentFloor, k, e.floor, e.lat);
            else n_pass++;
        end
        n_total++;
        if ({pending, up} !== 7'b0) $display("FAIL up_served: got %b want %b", {pending, up}, 7'b0);
        else n_pass++;
        @(negedge Clock);
        n_total++;
        if ({up, down, arrive} !== 3'b000) $display("FAIL up_arrive_width: got %b want %b", {up, down, arrive}, 3'b000);
        else n_pass++;
    endtask

    task automatic test_door();
        int k;
        bit to;
        exp_t e;
        sb.delete();
        repeat (2) @(negedge Clock);
        k = 0;
        inputfloors = 6'b000001;
        sb.push_back('{6'b000001, 39});
        @(negedge Clock); k = 1;
        inputfloors = '0;
        repeat (4) @(negedge Clock); k = 5;
        doorOpen = 1'b1;
        repeat (5) @(negedge Clock); k = 10;
        doorOpen = 1'b0;
        repeat (4) @(negedge Clock); k = 14;
        n_total++;
        if ({down, currentFloor} !== {1'b1, 6'b010000}) $display("FAIL door_frozen: got %b want %b", {down, currentFloor}, {1'b1, 6'b010000});
        else n_pass++;
        @(negedge Clock); k = 15;
        n_total++;
        if (currentFloor !== 6'b001000) $display("FAIL door_resume: got %b want %b", currentFloor, 6'b001000);
        else n_pass++;
        wait_arrive(70, k, to);
        n_total++;
        if (to) $display("FAIL door_arrive: timeout at cycle %0d", k);
        else begin
            e = sb.pop_front();
            if (currentFloor !== e.floor || k !== e.lat)
                $display("FAIL door_arrive: got floor %b cycle %0d want floor %b cycle %0d", currentFloor, k, e.floor, e.lat);
            else n_pass++;
        end
    endtask

    task automatic test_same_floor();
        int k;
        bit to;
        exp_t e;
        sb.delete();
        repeat (2) @(negedge Clock);
        k = 0;
        inputfloors = 6'b000001;
        sb.push_back('{6'b000001, 2});
        @(negedge Clock); k = 1;
        inputfloors = '0;
        n_total++;
        if ({pending, arrive} !== {6'b000001, 1'b0}) $display("FAIL same_latch: got %b want %b", {pending, arrive}, {6'b000001, 1'b0});
        else n_pass++;
        wait_arrive(6, k, to);
        n_total++;
        if (to) $display("FAIL same_arrive: timeout at cycle %0d", k);
        else begin
            e = sb.pop_front();
            if (currentFloor !== e.floor || k !== e.lat || pending !== 6'b0)
                $display("FAIL same_arrive: got floor %b cycle %0d pending %b want floor %b cycle %0d pending 0",
                         currentFloor, k, pending, e.floor, e.lat);
            else n_pass++;
        end
        @(negedge Clock);
        n_total++;
        if ({pending, arrive} !== 7'b0) $display("FAIL same_after: got %b want %b", {pending, arrive}, 7'b0);
        else n_pass++;
    endtask

    task automatic test_direction();
        int k;
        bit to;
        exp_t e;
        sb.delete();
        repeat (2) @(negedge Clock);
        k = 0;
        inputfloors = 6'b100000;
        sb.push_back('{6'b100000, 42});
        sb.push_back('{6'b000001, 84});
        @(negedge Clock); k = 1;
        inputfloors = '0;
        repeat (17) @(negedge Clock); k = 18;
        n_total++;
        if ({up, currentFloor} !== {1'b1, 6'b000100}) $display("FAIL dir_at_2m: got %b want %b", {up, currentFloor}, {1'b1, 6'b000100});
        else n_pass++;
        inputfloors = 6'b000001;
        @(negedge Clock); k = 19;
        inputfloors = '0;
        n_total++;
        if (pending !== 6'b100001) $display("FAIL dir_pending: got %b want %b", pending, 6'b100001);
        else n_pass++;
        wait_arrive(60, k, to);
        n_total++;
        if (to) $display("FAIL dir_arrive_top: timeout at cycle %0d", k);
        else begin
            e = sb.pop_front();
            if (currentFloor !== e.floor || k !== e.lat)
                $display("FAIL dir_arrive_top: got floor %b cycle %0d want floor %b cycle %0d", currentFloor, k, e.floor, e.lat);
            else n_pass++;
        end
        @(negedge Clock); k++;
        n_total++;
        if ({up, down, arrive} !== 3'b000) $display("FAIL dir_idle: got %b want %b", {up, down, arrive}, 3'b000);
        else n_pass++;
        @(negedge Clock); k++;
        n_total++;
        if (down !== 1'b1) $display("FAIL dir_reverse: got %b want 1", down);
        else n_pass++;
        wait_arrive(120, k, to);
        n_total++;
        if (to) $display("FAIL dir_arrive_bottom: timeout at cycle %0d", k);
        else begin
            e = sb.pop_front();
            if (currentFloor !== e.floor || k !== e.lat)
                $display("FAIL dir_arrive_bottom: got floor %b cycle %0d want floor %b cycle %0d", currentFloor, k, e.floor, e.lat);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int k;
        bit to;
        exp_t e;
        sb.delete();
        repeat (2) @(negedge Clock);
        k = 0;
        inputfloors = 6'b001010;
        sb.push_back('{6'b000010, 10});
        sb.push_back('{6'b001000, 27});
        @(negedge Clock); k = 1;
        inputfloors = '0;
        for (int i = 0; i < 2; i++) begin
            wait_arrive(40, k, to);
            n_total++;
            if (to) $display("FAIL b2b_arrive%0d: timeout at cycle %0d", i, k);
            else begin
                e = sb.pop_front();
                if (currentFloor !== e.floor || k !== e.lat)
                    $display("FAIL b2b_arrive%0d: got floor %b cycle %0d want floor %b cycle %0d", i, currentFloor, k, e.floor, e.lat);
                else n_pass++;
            end
        end
        @(negedge Clock);
        n_total++;
        if ({pending, up, down, arrive} !== 9'b0) $display("FAIL b2b_done: got %b want %b", {pending, up, down, arrive}, 9'b0);
        else n_pass++;
    endtask

`ifdef CAR_ARRIVE_HOLD_EN
    task automatic test_hold();
        int k;
        repeat (2) @(negedge Clock);
        k = 0;
        inputfloors = currentFloor;
        @(negedge Clock); k = 1;
        inputfloors = '0;
        @(negedge Clock); k = 2;
        n_total++;
        if (arrive !== 1'b1) $display("FAIL hold_enter: got %b want 1", arrive);
        else n_pass++;
        doorOpen = 1'b1;
        repeat (6) @(negedge Clock); k = 8;
        doorOpen = 1'b0;
        n_total++;
        if (arrive !== 1'b1) $display("FAIL hold_door: got %b want 1", arrive);
        else n_pass++;
        @(negedge Clock); k = 9;
        n_total++;
        if (arrive !== 1'b0) $display("FAIL hold_release: got %b want 0", arrive);
        else n_pass++;
    endtask
`endif

    initial begin
        n_pass = 0;
        n_total = 0;
        Reset = 1'b0;
        inputfloors = '0;
        doorOpen = 1'b0;
        test_reset();
        test_single_up();
        test_door();
        test_same_floor();
        test_direction();
        test_back_to_back();
`ifdef CAR_ARRIVE_HOLD_EN
        test_hold();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
